// File: rtl/bit_population_counter_pipe.sv
// Pipelined population counter: per-lane bit counts feed a registered adder tree.
// A single global enable stalls every stage whenever the output is held by the sink.
module bit_population_counter_pipe #(
  parameter int WIDTH      = 64,
  parameter int LANE_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   mode_i,
  input  logic                   data_val_i,
  output logic                   data_ready_o,
  output logic [$clog2(WIDTH):0] data_o,
  output logic                   data_val_o,
  input  logic                   ready_i
);

  localparam int NUM_LANES = (WIDTH + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int LEVELS    = $clog2(NUM_LANES);
  localparam int CW        = $clog2(WIDTH) + 1;
  localparam int EXT_W     = NUM_LANES * LANE_WIDTH;

  logic enable;

  assign enable       = !data_val_o || ready_i;
  assign data_ready_o = enable;

  // Padding bits stay zero after the optional inversion, so they never count.
  logic [EXT_W-1:0]                word_ext;
  logic [NUM_LANES-1:0][CW-1:0]    lane_cnt;

  always_comb begin
    word_ext            = '0;
    word_ext[WIDTH-1:0] = mode_i ? ~data_i : data_i;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_cnt[i] = '0;
      for (int j = 0; j < LANE_WIDTH; j++) begin
        lane_cnt[i] = lane_cnt[i] + CW'(word_ext[i*LANE_WIDTH + j]);
      end
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N_CUR = (NUM_LANES + (1 << l) - 1) >> l;

    logic [N_CUR-1:0][CW-1:0] cnt;
    logic                     vld;

    if (l == 0) begin : g_lane
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          cnt <= '0;
          vld <= 1'b0;
        end else if (enable) begin
          vld <= data_val_i;
          if (data_val_i) cnt <= lane_cnt;
        end
      end
    end else begin : g_sum
      localparam int N_PREV = (NUM_LANES + (1 << (l - 1)) - 1) >> (l - 1);

      logic [N_CUR-1:0][CW-1:0] nxt;

      // An unpaired last element passes through to the next level unchanged.
      for (genvar i = 0; i < N_CUR; i++) begin : g_pair
        if (2*i + 1 < N_PREV) begin : g_add
          assign nxt[i] = g_lvl[l-1].cnt[2*i] + g_lvl[l-1].cnt[2*i+1];
        end else begin : g_pass
          assign nxt[i] = g_lvl[l-1].cnt[2*i];
        end
      end

      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          cnt <= '0;
          vld <= 1'b0;
        end else if (enable) begin
          vld <= g_lvl[l-1].vld;
          if (g_lvl[l-1].vld) cnt <= nxt;
        end
      end
    end
  end

  assign data_o     = g_lvl[LEVELS].cnt[0];
  assign data_val_o = g_lvl[LEVELS].vld;

endmodule
